keep_one_in_n_vec_avg: RTL

Multi-lane decimator for the RFNoC sample path, and successor to the single-lane keep-one-in-N stage. Each beat carries NUM_CH packed lanes. The block keeps every Nth beat (KEEP mode) or emits the shifted, saturated sum of each N-beat window (AVG mode). Compared with the single-lane stage it adds three things: N changes take effect only at a window boundary, a tlast that falls inside a window is carried to the window's output, and the output is registered.

---
 rtl/keep_one_in_n_vec_avg_pkg.sv | 30 +++
 rtl/keep_one_in_n_vec_avg_lane_accum.sv | 42 ++++
 rtl/keep_one_in_n_vec_avg.sv | 139 +++++++++++++
 3 files changed

// File: rtl/keep_one_in_n_vec_avg_pkg.sv
// Shared constants and helpers for the multi-lane keep-one-in-N / window-average decimator.
package keep_one_in_n_pkg;

    localparam logic MODE_KEEP = 1'b0;
    localparam logic MODE_AVG  = 1'b1;
    localparam int   SAT_W     = 64;

    // Arithmetic right shift followed by clamping to a signed 'width'-bit range.
    // The result is sign-correct in its low 'width' bits, so callers take only those.
    function automatic logic [SAT_W-1:0] sat_shift(
        input logic signed [SAT_W-1:0] acc,
        input logic        [5:0]       shift,
        input int                      width
    );
        logic signed [SAT_W-1:0] shifted;
        logic signed [SAT_W-1:0] hi;
        logic signed [SAT_W-1:0] lo;
        shifted = acc >>> shift;
        hi      = (64'sd1 <<< (width - 1)) - 64'sd1;
        lo      = -(64'sd1 <<< (width - 1));
        if (shifted > hi) begin
            sat_shift = hi;
        end else if (shifted < lo) begin
            sat_shift = lo;
        end else begin
            sat_shift = shifted;
        end
    endfunction

endpackage

// File: rtl/keep_one_in_n_vec_avg_lane_accum.sv
// One lane's window accumulator; result is the shifted, saturated sum including the current beat.
module lane_accum
    import keep_one_in_n_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int ACC_W = 32,
    parameter int SW    = 5
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [WIDTH-1:0] lane,
    input  logic             add_en,
    input  logic             clr,
    input  logic [SW-1:0]    shift,
    output logic [WIDTH-1:0] result
);

    logic signed [ACC_W-1:0] acc_r;
    logic signed [ACC_W-1:0] lane_ext_s;
    logic signed [ACC_W-1:0] sum_s;

    // Sign-extend the lane and form the running sum used both for accumulation and output.
    always_comb begin
        lane_ext_s = {{(ACC_W-WIDTH){lane[WIDTH-1]}}, lane};
        sum_s      = acc_r + lane_ext_s;
        result     = WIDTH'(sat_shift({{(SAT_W-ACC_W){sum_s[ACC_W-1]}}, sum_s}, 6'(shift), WIDTH));
    end

    // Accumulator register: cleared when the window's last beat is taken.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            acc_r <= {ACC_W{1'b0}};
        end else if (clr) begin
            acc_r <= {ACC_W{1'b0}};
        end else if (add_en) begin
            acc_r <= sum_s;
        end else begin
            acc_r <= acc_r;
        end
    end

endmodule

// File: rtl/keep_one_in_n_vec_avg.sv
// Multi-lane decimator: keeps every Nth beat or emits the shifted, saturated N-beat sum per lane.
module keep_one_in_n_vec_avg
    import keep_one_in_n_pkg::*;
#(
    parameter int WIDTH  = 16,
    parameter int NUM_CH = 2,
    parameter int MAX_N  = 65535,
    parameter int NW     = $clog2(MAX_N + 1),
    parameter int ACC_W  = WIDTH + NW,
    parameter int SW     = $clog2(ACC_W)
) (
    input  logic                    clk,
    input  logic                    reset_n,
    input  logic [NW-1:0]           n,
    input  logic                    mode,
    input  logic [SW-1:0]           shift,
    input  logic [NUM_CH*WIDTH-1:0] i_tdata,
    input  logic                    i_tlast,
    input  logic                    i_tvalid,
    output logic                    i_tready,
    output logic [NUM_CH*WIDTH-1:0] o_tdata,
    output logic                    o_tlast,
    output logic                    o_tvalid,
    input  logic                    o_tready
);

    localparam logic [NW-1:0] CNT_ONE = {{(NW-1){1'b0}}, 1'b1};

    logic [NW-1:0]           n_act_r;
    logic                    mode_act_r;
    logic [SW-1:0]           shift_act_r;
    logic [NW-1:0]           sample_cnt_r;
    logic [NW-1:0]           pkt_cnt_r;
    logic                    pend_last_r;
    logic [NW-1:0]           n_eff_s;
    logic                    last_sample_s;
    logic                    last_pkt_s;
    logic                    accept_s;
    logic                    load_s;
    logic                    pkt_wrap_s;
    logic                    cfg_load_s;
    logic                    avg_en_s;
    logic                    out_last_s;
    logic [NUM_CH*WIDTH-1:0] avg_data_s;
    logic [NUM_CH*WIDTH-1:0] out_data_s;

    // Window position, handshake and output selection.
    always_comb begin
        n_eff_s       = (n_act_r == {NW{1'b0}}) ? CNT_ONE : n_act_r;
        last_sample_s = (sample_cnt_r >= n_eff_s);
        last_pkt_s    = (pkt_cnt_r >= n_eff_s);
        // Only a window-closing beat needs the output register, so only it can stall.
        i_tready      = ~o_tvalid | o_tready | ~last_sample_s;
        accept_s      = i_tvalid & i_tready;
        load_s        = accept_s & last_sample_s;
        pkt_wrap_s    = accept_s & i_tlast & last_pkt_s;
        cfg_load_s    = (load_s & pkt_wrap_s) |
                        ((sample_cnt_r == CNT_ONE) & (pkt_cnt_r == CNT_ONE) & ~accept_s);
        avg_en_s      = accept_s & ~last_sample_s & (mode_act_r == MODE_AVG);
        out_last_s    = (i_tlast & last_pkt_s) | pend_last_r;
        out_data_s    = (mode_act_r == MODE_AVG) ? avg_data_s : i_tdata;
    end

    for (genvar k = 0; k < NUM_CH; k++) begin : g_lane
        lane_accum #(
            .WIDTH (WIDTH),
            .ACC_W (ACC_W),
            .SW    (SW)
        ) u_lane (
            .clk     (clk),
            .reset_n (reset_n),
            .lane    (i_tdata[k*WIDTH +: WIDTH]),
            .add_en  (avg_en_s),
            .clr     (load_s),
            .shift   (shift_act_r),
            .result  (avg_data_s[k*WIDTH +: WIDTH])
        );
    end

    // Sample/packet counters and the active configuration, reloaded only at window boundaries.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sample_cnt_r <= CNT_ONE;
            pkt_cnt_r    <= CNT_ONE;
            n_act_r      <= CNT_ONE;
            mode_act_r   <= MODE_KEEP;
            shift_act_r  <= {SW{1'b0}};
        end else begin
            if (accept_s) begin
                sample_cnt_r <= last_sample_s ? CNT_ONE : sample_cnt_r + CNT_ONE;
            end else begin
                sample_cnt_r <= sample_cnt_r;
            end
            if (accept_s & i_tlast) begin
                pkt_cnt_r <= last_pkt_s ? CNT_ONE : pkt_cnt_r + CNT_ONE;
            end else begin
                pkt_cnt_r <= pkt_cnt_r;
            end
            if (cfg_load_s) begin
                n_act_r     <= n;
                mode_act_r  <= mode;
                shift_act_r <= shift;
            end else begin
                n_act_r     <= n_act_r;
                mode_act_r  <= mode_act_r;
                shift_act_r <= shift_act_r;
            end
        end
    end

    // Output register and the tlast carried from inside a window to its output.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            o_tvalid    <= 1'b0;
            o_tdata     <= {(NUM_CH*WIDTH){1'b0}};
            o_tlast     <= 1'b0;
            pend_last_r <= 1'b0;
        end else if (load_s) begin
            o_tvalid    <= 1'b1;
            o_tdata     <= out_data_s;
            o_tlast     <= out_last_s;
            pend_last_r <= 1'b0;
        end else begin
            if (o_tready) begin
                o_tvalid <= 1'b0;
            end else begin
                o_tvalid <= o_tvalid;
            end
            o_tdata <= o_tdata;
            o_tlast <= o_tlast;
            if (pkt_wrap_s) begin
                pend_last_r <= 1'b1;
            end else begin
                pend_last_r <= pend_last_r;
            end
        end
    end

endmodule
